duty_meter_mc: RTL and testbench
================================

DUTY_METER_MC -- requirements
Module: duty_meter_mc

Interface
REQ-001 Parameter CH, default 4: number of independent measurement channels, 1..16.
REQ-002 Parameter CW, default 32: counter and result width in bits, 8..32.
REQ-003 Parameter SYNC, default 2: input synchroniser depth in flops, 2..4.
REQ-004 Parameter TIMEOUT, default 32'd50_000_000: idle-cycle limit for stuck detection; used only with the macro.
REQ-005 clk  in  1  clock.
REQ-006 reset  in  1  asynchronous, active-low reset.
REQ-007 sig  in  CH  asynchronous measured inputs, one bit per channel.
REQ-008 meas_ack  in  CH  per-channel result acknowledge, level-sampled.
REQ-009 high_time  out  CH*CW  per-channel high-time result in clk cycles, channel n at bits [n*CW +: CW].
REQ-010 period  out  CH*CW  per-channel rising-to-rising period result in clk cycles, same packing.
REQ-011 meas_valid  out  CH  result-available flag.
REQ-012 ovf  out  CH  captured result saturated.
REQ-013 overrun  out  CH  sticky flag: an unacknowledged result was overwritten.
REQ-014 stuck  out  CH  no rising edge seen within TIMEOUT cycles.
REQ-015 stuck_level  out  CH  synchronised level of a stuck channel.

Function
REQ-016 Each channel shall pass sig[n] through SYNC flops, then one edge-detect flop; a rising edge is synchronised level 1 with the previous level 0.
REQ-017 The period counter shall clear to 0 on the rising-edge cycle and increment by 1 on every other cycle.
REQ-018 The high counter shall load 1 on the rising-edge cycle and increment on every other cycle where the synchronised level is 1.
REQ-019 Both counters shall saturate at 2^CW-1 and never wrap.
REQ-020 On a rising-edge cycle with the channel armed, the block shall capture period = period_cnt+1 and high_time = high_cnt, each saturated to 2^CW-1, and ovf = either value saturated.
REQ-021 The first rising edge after reset, or after a stuck condition, shall only arm the channel; no capture and no meas_valid.
REQ-022 Captured outputs and meas_valid shall update in the cycle after the rising-edge cycle; sig to meas_valid latency is SYNC+2 clk cycles.
REQ-023 meas_valid shall set on capture and clear on the cycle after meas_ack=1 with no simultaneous capture.
REQ-024 If a capture occurs while meas_valid=1 and meas_ack=0, the data shall be overwritten and overrun set.
REQ-025 If capture and meas_ack coincide, the data shall update, meas_valid shall stay 1, and overrun shall be unchanged.
REQ-026 overrun shall clear only on meas_ack=1 with no simultaneous overrun event.
REQ-027 Channels shall be fully independent; simultaneous edges on several channels shall each capture in the same cycle.

Reset
REQ-028 reset=0 shall asynchronously clear all synchroniser flops, counters, armed flags, high_time, period, meas_valid, ovf, overrun, stuck and stuck_level to 0.
REQ-029 Reset asserted mid-period shall discard the partial measurement; after release the next two rising edges shall be required before meas_valid.

Configuration
REQ-030 With DUTY_METER_TIMEOUT_EN defined, stuck[n] shall set when period_cnt reaches TIMEOUT-1, and shall also disarm the channel and latch stuck_level.
REQ-031 With DUTY_METER_TIMEOUT_EN defined, stuck[n] shall clear on the next rising edge, which only re-arms the channel.
REQ-032 Without DUTY_METER_TIMEOUT_EN, stuck and stuck_level shall be constant 0, no timeout logic shall exist, and TIMEOUT shall be ignored.

Structure
REQ-033 Package duty_meter_pkg shall hold the default parameter constants, the saturate-max constant function, and the TIMEOUT default.
REQ-034 Per-channel logic shall be sub-module duty_meter_ch, instantiated CH times by a generate loop; the top shall contain only packing.

Verification
REQ-035 CH=2, CW=16: ch0 square wave with period 10 and high 3 -> from the second rising edge, period=10, high_time=3, meas_valid at edge+4 cycles (SYNC=2).
REQ-036 CW=8, ch1 period 300 and high 280 -> period=255, high_time=255, ovf=1; next 100-cycle period -> ovf=0.
REQ-037 No ack over three consecutive captures -> overrun=1 and last data shown; capture coinciding with ack -> meas_valid stays 1 and overrun unchanged.
REQ-038 Macro defined, TIMEOUT=1000, sig held 1 -> stuck=1 and stuck_level=1 at 1000 idle cycles; next edge clears stuck, and meas_valid only after the following edge.
REQ-039 reset pulsed mid-high phase -> all outputs 0 asynchronously, and the first post-reset edge produces no capture.
REQ-040 Simultaneous edges on all channels with different periods -> each channel captures its own correct period in the same cycle.

Source files
------------

// File: rtl/duty_meter_pkg.sv
// Shared constants and helpers for the multi-channel duty/period meter.
// Optional stuck-input timeout is enabled by defining DUTY_METER_TIMEOUT_EN.
package duty_meter_pkg;

  localparam int unsigned DefCh      = 4;
  localparam int unsigned DefCw      = 32;
  localparam int unsigned DefSync    = 2;
  localparam int unsigned DefTimeout = 32'd50_000_000;

  // All-ones value of a cw-bit counter, computed in 32 bits.
  function automatic logic [31:0] sat_max(input int unsigned cw);
    if (cw >= 32) begin
      return 32'hFFFF_FFFF;
    end
    return (32'd1 << cw) - 32'd1;
  endfunction

endpackage

// File: rtl/duty_meter_ch.sv
// One measurement channel: synchroniser, edge detect, saturating counters, result handshake.
// Stuck-input detection exists only when DUTY_METER_TIMEOUT_EN is defined.
module duty_meter_ch
  import duty_meter_pkg::*;
#(
  parameter int unsigned CW      = DefCw,
  parameter int unsigned SYNC    = DefSync,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sig,
  input  logic          meas_ack,
  output logic [CW-1:0] high_time,
  output logic [CW-1:0] period,
  output logic          meas_valid,
  output logic          ovf,
  output logic          overrun,
  output logic          stuck,
  output logic          stuck_level
);

  localparam logic [CW-1:0] CntMax = CW'(sat_max(CW));
  localparam logic [CW-1:0] CntOne = {{(CW-1){1'b0}}, 1'b1};

  logic [SYNC-1:0] sync_q;
  logic            lvl_q, rise_q;
  logic [CW-1:0]   period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
  logic [CW-1:0]   period_q, period_d, high_q, high_d;
  logic            armed_q, armed_d, valid_q, valid_d;
  logic            ovf_q, ovf_d, overrun_q, overrun_d;
  logic            per_max, high_max, cap, timeout_hit;

  assign per_max  = (period_cnt_q == CntMax);
  assign high_max = (high_cnt_q == CntMax);
  assign cap      = rise_q & armed_q;

  // rise_q and lvl_q are aligned: rise_q marks the first cycle lvl_q is high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      lvl_q  <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], sig};
      lvl_q  <= sync_q[SYNC-1];
      rise_q <= sync_q[SYNC-1] & ~lvl_q;
    end
  end

  always_comb begin
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    armed_d      = armed_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    period_d     = period_q;
    high_d       = high_q;
    ovf_d        = ovf_q;
    if (rise_q) begin
      period_cnt_d = '0;
      high_cnt_d   = CntOne;
      armed_d      = 1'b1;
    end else begin
      if (!per_max) period_cnt_d = period_cnt_q + CntOne;
      if (lvl_q && !high_max) high_cnt_d = high_cnt_q + CntOne;
      if (timeout_hit) armed_d = 1'b0;
    end
    if (cap) begin
      period_d = per_max ? CntMax : period_cnt_q + CntOne;
      high_d   = high_cnt_q;
      ovf_d    = per_max | high_max;
      valid_d  = 1'b1;
    end else if (meas_ack) begin
      valid_d = 1'b0;
    end
    // A capture coinciding with an ack leaves overrun untouched.
    if (cap && valid_q && !meas_ack) begin
      overrun_d = 1'b1;
    end else if (meas_ack && !cap) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      armed_q      <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      period_q     <= '0;
      high_q       <= '0;
      ovf_q        <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      armed_q      <= armed_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      period_q     <= period_d;
      high_q       <= high_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef DUTY_METER_TIMEOUT_EN
  logic stuck_q, stuck_d, stuck_lvl_q, stuck_lvl_d;

  assign timeout_hit = !rise_q && !stuck_q && (32'(period_cnt_q) == TIMEOUT - 32'd1);

  always_comb begin
    stuck_d     = stuck_q;
    stuck_lvl_d = stuck_lvl_q;
    if (rise_q) begin
      stuck_d     = 1'b0;
      stuck_lvl_d = 1'b0;
    end else if (timeout_hit) begin
      stuck_d     = 1'b1;
      stuck_lvl_d = lvl_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stuck_q     <= 1'b0;
      stuck_lvl_q <= 1'b0;
    end else begin
      stuck_q     <= stuck_d;
      stuck_lvl_q <= stuck_lvl_d;
    end
  end

  assign stuck       = stuck_q;
  assign stuck_level = stuck_lvl_q;
`else
  assign timeout_hit = 1'b0;
  assign stuck       = 1'b0;
  assign stuck_level = 1'b0;
`endif

  assign high_time  = high_q;
  assign period     = period_q;
  assign meas_valid = valid_q;
  assign ovf        = ovf_q;
  assign overrun    = overrun_q;

endmodule

// File: rtl/duty_meter_mc.sv
// Multi-channel duty/period meter top: one duty_meter_ch per channel, outputs packed by channel.
// Define DUTY_METER_TIMEOUT_EN to build the stuck-input timeout.
module duty_meter_mc
  import duty_meter_pkg::*;
#(
  parameter int unsigned CH      = DefCh,
  parameter int unsigned CW      = DefCw,
  parameter int unsigned SYNC    = DefSync,
  parameter int unsigned TIMEOUT = DefTimeout
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [CH-1:0]    sig,
  input  logic [CH-1:0]    meas_ack,
  output logic [CH*CW-1:0] high_time,
  output logic [CH*CW-1:0] period,
  output logic [CH-1:0]    meas_valid,
  output logic [CH-1:0]    ovf,
  output logic [CH-1:0]    overrun,
  output logic [CH-1:0]    stuck,
  output logic [CH-1:0]    stuck_level
);

  for (genvar n = 0; n < CH; n++) begin : g_ch
    duty_meter_ch #(
      .CW     (CW),
      .SYNC   (SYNC),
      .TIMEOUT(TIMEOUT)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .sig        (sig[n]),
      .meas_ack   (meas_ack[n]),
      .high_time  (high_time[n*CW +: CW]),
      .period     (period[n*CW +: CW]),
      .meas_valid (meas_valid[n]),
      .ovf        (ovf[n]),
      .overrun    (overrun[n]),
      .stuck      (stuck[n]),
      .stuck_level(stuck_level[n])
    );
  end

endmodule

// File: tb/tb_duty_meter_mc.sv
// Directed bench for duty_meter_mc: a CW=16 instance (a) and a CW=8 instance (b), both SYNC=2.
// Expectations for stuck depend on whether DUTY_METER_TIMEOUT_EN is defined.
module tb_duty_meter_mc;

  localparam int unsigned CWA = 16;
  localparam int unsigned CWB = 8;

  logic clk = 1'b0;
  logic reset;
  logic [1:0] sig_a, ack_a, sig_b, ack_b;
  logic [2*CWA-1:0] high_a, per_a;
  logic [2*CWB-1:0] high_b, per_b;
  logic [1:0] valid_a, ovf_a, ovr_a, stuck_a, slvl_a;
  logic [1:0] valid_b, ovf_b, ovr_b, stuck_b, slvl_b;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  duty_meter_mc #(.CH(2), .CW(CWA), .SYNC(2), .TIMEOUT(1000)) dut_a (
    .clk(clk), .reset(reset), .sig(sig_a), .meas_ack(ack_a), .high_time(high_a), .period(per_a),
    .meas_valid(valid_a), .ovf(ovf_a), .overrun(ovr_a), .stuck(stuck_a), .stuck_level(slvl_a)
  );

  duty_meter_mc #(.CH(2), .CW(CWB), .SYNC(2), .TIMEOUT(1000)) dut_b (
    .clk(clk), .reset(reset), .sig(sig_b), .meas_ack(ack_b), .high_time(high_b), .period(per_b),
    .meas_valid(valid_b), .ovf(ovf_b), .overrun(ovr_b), .stuck(stuck_b), .stuck_level(slvl_b)
  );

  function automatic logic sq(input int c, input int per, input int hi);
    return (c % per) < hi;
  endfunction

  task automatic do_reset();
    reset = 1'b0;
    sig_a = '0; sig_b = '0; ack_a = '0; ack_b = '0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; sig_a = '0; sig_b = '0; ack_a = '0; ack_b = '0;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({high_a, per_a, valid_a, ovf_a, ovr_a, stuck_a, slvl_a} !== '0) begin
      errors++; $display("FAIL reset_a got %h %h %b want all zero", high_a, per_a, valid_a);
    end
    checks++;
    if ({high_b, per_b, valid_b, ovf_b, ovr_b, stuck_b, slvl_b} !== '0) begin
      errors++; $display("FAIL reset_b got %h %h %b want all zero", high_b, per_b, valid_b);
    end
    do_reset();
  endtask

  // ch0 period 10 high 3: first edge only arms, second captures, visible 4 cycles later.
  task automatic test_single();
    do_reset();
    for (int c = 0; c < 16; c++) begin
      @(posedge clk); #1;
      if (c == 13) begin
        checks++;
        if (valid_a !== 2'b00) begin
          errors++; $display("FAIL single_early got %b want 00", valid_a);
        end
      end
      if (c == 14) begin
        checks++;
        if (valid_a !== 2'b01 || per_a[15:0] !== 16'd10 || high_a[15:0] !== 16'd3 ||
            ovf_a !== 2'b00) begin
          errors++;
          $display("FAIL single_capture got v=%b p=%0d h=%0d o=%b want v=01 p=10 h=3 o=00",
                   valid_a, per_a[15:0], high_a[15:0], ovf_a);
        end
      end
      sig_a[0] = sq(c, 10, 3);
    end
  endtask

  // CW=8: 300/280 saturates both results, then a 100/40 period is exact.
  task automatic test_ovf();
    do_reset();
    for (int c = 0; c < 405; c++) begin
      @(posedge clk); #1;
      if (c == 304) begin
        checks++;
        if (valid_b[1] !== 1'b1 || per_b[15:8] !== 8'd255 || high_b[15:8] !== 8'd255 ||
            ovf_b[1] !== 1'b1) begin
          errors++;
          $display("FAIL ovf_sat got v=%b p=%0d h=%0d o=%b want v=1 p=255 h=255 o=1",
                   valid_b[1], per_b[15:8], high_b[15:8], ovf_b[1]);
        end
      end
      if (c == 404) begin
        checks++;
        if (valid_b !== 2'b10 || per_b[15:8] !== 8'd100 || high_b[15:8] !== 8'd40 ||
            ovf_b[1] !== 1'b0 || ovr_b[1] !== 1'b0) begin
          errors++;
          $display("FAIL ovf_clear got v=%b p=%0d h=%0d o=%b r=%b want v=10 p=100 h=40 o=0 r=0",
                   valid_b, per_b[15:8], high_b[15:8], ovf_b[1], ovr_b[1]);
        end
      end
      if (c < 300) sig_b[1] = (c < 280);
      else if (c < 400) sig_b[1] = (c - 300 < 40);
      else sig_b[1] = 1'b1;
      ack_b[1] = (c == 350);
    end
  endtask

  // Edges at 0,10,22,36,52 give periods 10,12,14,16; ack meets the last capture.
  task automatic test_overrun();
    int e[5] = '{0, 10, 22, 36, 52};
    do_reset();
    for (int c = 0; c < 59; c++) begin
      @(posedge clk); #1;
      if (c == 25) begin
        checks++;
        if (ovr_a[0] !== 1'b0 || valid_a[0] !== 1'b1) begin
          errors++; $display("FAIL ovr_before got r=%b v=%b want r=0 v=1", ovr_a[0], valid_a[0]);
        end
      end
      if (c == 26) begin
        checks++;
        if (ovr_a[0] !== 1'b1 || per_a[15:0] !== 16'd12) begin
          errors++; $display("FAIL ovr_set got r=%b p=%0d want r=1 p=12", ovr_a[0], per_a[15:0]);
        end
      end
      if (c == 40) begin
        checks++;
        if (ovr_a[0] !== 1'b1 || valid_a[0] !== 1'b1 || per_a[15:0] !== 16'd14 ||
            high_a[15:0] !== 16'd3) begin
          errors++;
          $display("FAIL ovr_last got r=%b v=%b p=%0d h=%0d want r=1 v=1 p=14 h=3",
                   ovr_a[0], valid_a[0], per_a[15:0], high_a[15:0]);
        end
      end
      if (c == 56) begin
        checks++;
        if (ovr_a[0] !== 1'b1 || valid_a[0] !== 1'b1 || per_a[15:0] !== 16'd16) begin
          errors++;
          $display("FAIL ack_coincide got r=%b v=%b p=%0d want r=1 v=1 p=16",
                   ovr_a[0], valid_a[0], per_a[15:0]);
        end
      end
      if (c == 58) begin
        checks++;
        if (ovr_a[0] !== 1'b0 || valid_a[0] !== 1'b0) begin
          errors++; $display("FAIL ack_clear got r=%b v=%b want r=0 v=0", ovr_a[0], valid_a[0]);
        end
      end
      sig_a[0] = 1'b0;
      for (int i = 0; i < 5; i++) if (c >= e[i] && c < e[i] + 3) sig_a[0] = 1'b1;
      ack_a[0] = (c == 55) || (c == 57);
    end
  endtask

  // Both channels rise together at 0 and 60 with periods 12 and 20; ack held high.
  task automatic test_simul();
    do_reset();
    for (int c = 0; c < 65; c++) begin
      @(posedge clk); #1;
      if (c == 16) begin
        checks++;
        if (valid_a !== 2'b01 || per_a[15:0] !== 16'd12) begin
          errors++; $display("FAIL simul_ch0 got v=%b p=%0d want v=01 p=12", valid_a, per_a[15:0]);
        end
      end
      if (c == 24) begin
        checks++;
        if (valid_a !== 2'b10 || per_a[31:16] !== 16'd20) begin
          errors++; $display("FAIL simul_ch1 got v=%b p=%0d want v=10 p=20", valid_a, per_a[31:16]);
        end
      end
      if (c == 63) begin
        checks++;
        if (valid_a !== 2'b00) begin
          errors++; $display("FAIL simul_idle got v=%b want 00", valid_a);
        end
      end
      if (c == 64) begin
        checks++;
        if (valid_a !== 2'b11 || per_a[15:0] !== 16'd12 || per_a[31:16] !== 16'd20 ||
            high_a[15:0] !== 16'd5 || high_a[31:16] !== 16'd7) begin
          errors++;
          $display("FAIL simul_both got v=%b p0=%0d p1=%0d h0=%0d h1=%0d want 11 12 20 5 7",
                   valid_a, per_a[15:0], per_a[31:16], high_a[15:0], high_a[31:16]);
        end
      end
      sig_a[0] = sq(c, 12, 5);
      sig_a[1] = sq(c, 20, 7);
      ack_a = 2'b11;
    end
  endtask

  // sig held high from cycle 10; timeout of 1000 cycles, then re-arm at 1025, capture at 1035.
  task automatic test_stuck();
    do_reset();
    for (int c = 0; c < 1040; c++) begin
      @(posedge clk); #1;
      if (c == 14) begin
        checks++;
        if (valid_a[0] !== 1'b1 || per_a[15:0] !== 16'd10 || high_a[15:0] !== 16'd5) begin
          errors++;
          $display("FAIL stuck_pre got v=%b p=%0d h=%0d want v=1 p=10 h=5",
                   valid_a[0], per_a[15:0], high_a[15:0]);
        end
      end
      if (c == 1013) begin
        checks++;
        if (stuck_a[0] !== 1'b0) begin
          errors++; $display("FAIL stuck_early got %b want 0", stuck_a[0]);
        end
      end
      if (c == 1014) begin
        checks++;
`ifdef DUTY_METER_TIMEOUT_EN
        if (stuck_a[0] !== 1'b1 || slvl_a[0] !== 1'b1) begin
          errors++; $display("FAIL stuck_set got s=%b l=%b want s=1 l=1", stuck_a[0], slvl_a[0]);
        end
`else
        if (stuck_a !== 2'b00 || slvl_a !== 2'b00) begin
          errors++; $display("FAIL stuck_off got s=%b l=%b want 00 00", stuck_a, slvl_a);
        end
`endif
      end
      if (c == 1029) begin
        checks++;
`ifdef DUTY_METER_TIMEOUT_EN
        if (stuck_a[0] !== 1'b0 || slvl_a[0] !== 1'b0 || valid_a[0] !== 1'b0) begin
          errors++;
          $display("FAIL stuck_rearm got s=%b l=%b v=%b want 0 0 0",
                   stuck_a[0], slvl_a[0], valid_a[0]);
        end
`else
        if (stuck_a[0] !== 1'b0 || valid_a[0] !== 1'b1 || per_a[15:0] !== 16'd1015 ||
            high_a[15:0] !== 16'd1010) begin
          errors++;
          $display("FAIL long_period got s=%b v=%b p=%0d h=%0d want 0 1 1015 1010",
                   stuck_a[0], valid_a[0], per_a[15:0], high_a[15:0]);
        end
`endif
      end
      if (c == 1039) begin
        checks++;
        if (valid_a[0] !== 1'b1 || per_a[15:0] !== 16'd10 || high_a[15:0] !== 16'd5) begin
          errors++;
          $display("FAIL stuck_after got v=%b p=%0d h=%0d want v=1 p=10 h=5",
                   valid_a[0], per_a[15:0], high_a[15:0]);
        end
      end
      if (c < 10) sig_a[0] = (c < 5);
      else if (c < 1020) sig_a[0] = 1'b1;
      else sig_a[0] = sq(c - 1020, 10, 5) ? 1'b0 : 1'b1;
      ack_a[0] = (c == 20);
    end
  endtask

  // Reset pulsed while ch0 is high discards everything; first post-reset edge only arms.
  task automatic test_reset_mid();
    do_reset();
    for (int c = 0; c < 45; c++) begin
      @(posedge clk); #1;
      if (c == 14) begin
        checks++;
        if (valid_a[0] !== 1'b1) begin
          errors++; $display("FAIL mid_pre got v=%b want 1", valid_a[0]);
        end
      end
      if (c == 34) begin
        checks++;
        if (valid_a !== 2'b00) begin
          errors++; $display("FAIL mid_first_edge got v=%b want 00", valid_a);
        end
      end
      if (c == 44) begin
        checks++;
        if (valid_a[0] !== 1'b1 || per_a[15:0] !== 16'd10 || high_a[15:0] !== 16'd3) begin
          errors++;
          $display("FAIL mid_second_edge got v=%b p=%0d h=%0d want v=1 p=10 h=3",
                   valid_a[0], per_a[15:0], high_a[15:0]);
        end
      end
      sig_a[0] = sq(c, 10, 3);
      if (c == 21) begin
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({high_a, per_a, valid_a, ovf_a, ovr_a, stuck_a, slvl_a} !== '0) begin
          errors++;
          $display("FAIL mid_async got h=%h p=%h v=%b want all zero", high_a, per_a, valid_a);
        end
      end
      if (c == 25) reset = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_ovf();
    test_overrun();
    test_simul();
    test_stuck();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
